aes_wb_master: RTL and testbench
================================

# aes_wb_master

Wishbone B4 classic-cycle master that runs one complete AES operation against the memory-mapped AES control slave: writes key and input block, starts the core, polls busy, reads back the result. It sits on the Wishbone clock domain, next to the slave, and replaces software-driven register sequencing for autonomous capture runs. One command is accepted at a time through a ready/start handshake.

## Interface
- KEY_BASE, 32'h00, byte address of key word 0; word i at KEY_BASE+4*i, bits [32i+31:32i]
- DIN_BASE, 32'h20, byte address of input-block word 0 (4 words, same ordering)
- DOUT_BASE, 32'h30, byte address of output-block word 0 (4 words, same ordering)
- CTRL_ADDR, 32'h40, control register: bit0 load, bit1 dec, bits[3:2] size
- STATUS_ADDR, 32'h44, status register: bit0 busy
- SETTLE, 4, idle cycles after control write before first status read (covers two-flop busy synchronisers); legal 1..15
- TIMEOUT, 4096, maximum status reads before abort (only with timeout macro)
- wb_clk_i  in  1  clock
- wb_rstn_i  in  1  reset; asynchronous, active-low
- start_i  in  1  command request; accepted when start_i && ready_o
- key_i  in  256  key; words beyond the selected size ignored
- data_i  in  128  input block
- dec_i  in  1  1 = decrypt
- size_i  in  2  0 = AES-128, 1 = AES-192, 2 = AES-256; 3 illegal
- ready_o  out  1  idle, accepting a command
- data_o  out  128  result block, valid from done_o until next accepted command
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle abort pulse (bus error, illegal size, timeout)
- wb_adr_o  out  32  address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  always 4'hF during a cycle
- wb_we_o  out  1  write enable
- wb_cyc_o, wb_stb_o  out  1 each  cycle/strobe, always equal
- wb_cti_o  out  3  always 3'b000; wb_bte_o  out  2  always 2'b00
- wb_dat_i  in  32  read data
- wb_ack_i, wb_err_i, wb_rty_i  in  1 each  termination

## Operation
- Reset: ready_o=1, done_o=0, err_o=0, data_o=0, cyc/stb/we=0, adr/dat=0, sel=0, FSM IDLE.
- Acceptance latches key_i, data_i, dec_i, size_i; ready_o drops next cycle. size_i=3 -> no bus traffic, err_o pulse, back to IDLE.
- States: IDLE -> WR_KEY (4/6/8 words for size 0/1/2, word 0 first) -> WR_DIN (4 words) -> WR_CTRL (data {28'b0,size,dec,1'b1}) -> SETTLE (count SETTLE cycles) -> POLL (read STATUS_ADDR; busy=1 -> gap, reread; busy=0 -> next) -> RD_DOUT (4 reads into data_o word i) -> DONE (done_o=1 one cycle) -> IDLE.
- Every access: cyc/stb held with stable adr/dat/we until ack, err or rty. ack advances; rty repeats same access after gap; err aborts.
- Abort: drop cyc/stb, err_o pulse one cycle, IDLE; data_o keeps previous value.
- start_i ignored while not ready_o.
- ack/err/rty while cyc_o=0 ignored. Simultaneous terminations: err > rty > ack.
- Reset asserted mid-cycle: outputs immediately return to reset values; no completion.

## Timing
- Access: strobe asserted cycle N; termination sampled on cycle ≥N; cyc/stb low exactly one cycle after every termination.
- Zero-wait slave, AES-128, busy low at first poll: 9 writes + 1 read status + 4 reads = 14 accesses x 2 = 28 cycles + SETTLE + 1 accept + 1 done.
- done_o rises the cycle after the last read ack; ready_o high the following cycle.
- data_o word i updated on the cycle of its read ack.

## Configuration
- AES_WB_MASTER_TIMEOUT_EN defined: POLL counts status reads; after TIMEOUT reads with busy=1, abort with err_o. Counter cleared on entering POLL.
- Undefined: no counter, POLL waits indefinitely; TIMEOUT unused.

## Test plan
- FIPS-197 AES-128 (key 000102..0f, pt 00112233..ff), zero-wait model -> 9 writes at 0x00..0x0C, 0x20..0x2C, 0x40 data 0x1; data_o = 69c4e0d86a7b0430d8cdb78070b4c55a; done_o one pulse.
- AES-256 decrypt, slave busy for 10 status reads -> 8 key writes, ctrl data 0xB, 11 status reads, correct plaintext.
- Slave asserts rty twice on DIN word 2 then ack -> same address/data reissued, one gap cycle each, normal completion.
- wb_err_i on second key write -> err_o pulse, no further accesses, ready_o high, data_o unchanged.
- size_i=3 -> err_o the cycle after acceptance, cyc_o never asserted; with AES_WB_MASTER_TIMEOUT_EN, TIMEOUT=8, busy stuck -> exactly 8 reads then err_o.
- wb_rstn_i low during POLL -> cyc_o=0, ready_o=1 immediately; subsequent command completes normally.

Source files
------------

// File: rtl/aes_wb_master.sv
// aes_wb_master: Wishbone B4 classic-cycle master that sequences one AES
// operation on the memory-mapped AES slave. It writes the key words, the
// input-block words and the control word, waits a settle interval, polls
// the busy flag, then reads the four result words.
// Optional feature: define AES_WB_MASTER_TIMEOUT_EN to bound the busy poll
// to TIMEOUT status reads. Without it, the poll waits indefinitely.
module aes_wb_master #(
    parameter logic [31:0] KEY_BASE    = 32'h0000_0000,
    parameter logic [31:0] DIN_BASE    = 32'h0000_0020,
    parameter logic [31:0] DOUT_BASE   = 32'h0000_0030,
    parameter logic [31:0] CTRL_ADDR   = 32'h0000_0040,
    parameter logic [31:0] STATUS_ADDR = 32'h0000_0044,
    parameter int unsigned SETTLE      = 4
`ifdef AES_WB_MASTER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT     = 4096
`endif
) (
    input  logic         wb_clk_i,
    input  logic         wb_rstn_i,
    input  logic         start_i,
    input  logic [255:0] key_i,
    input  logic [127:0] data_i,
    input  logic         dec_i,
    input  logic [1:0]   size_i,
    output logic         ready_o,
    output logic [127:0] data_o,
    output logic         done_o,
    output logic         err_o,
    output logic [31:0]  wb_adr_o,
    output logic [31:0]  wb_dat_o,
    output logic [3:0]   wb_sel_o,
    output logic         wb_we_o,
    output logic         wb_cyc_o,
    output logic         wb_stb_o,
    output logic [2:0]   wb_cti_o,
    output logic [1:0]   wb_bte_o,
    input  logic [31:0]  wb_dat_i,
    input  logic         wb_ack_i,
    input  logic         wb_err_i,
    input  logic         wb_rty_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_KEY, S_WR_DIN, S_WR_CTRL, S_SETTLE, S_POLL, S_RD_DOUT, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic           cyc_q, cyc_d, we_q, we_d;
    logic [31:0]    adr_q, adr_d, dat_q, dat_d;
    logic [3:0]     sel_q, sel_d;
    logic [2:0]     idx_q, idx_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [255:0]   key_q, key_d;
    logic [127:0]   din_q, din_d, data_q, data_d;
    logic           dec_q, dec_d, ready_q, ready_d, done_q, done_d, err_q, err_d;
    logic [1:0]     size_q, size_d;
    logic           accept_s, issue_s;
`ifdef AES_WB_MASTER_TIMEOUT_EN
    localparam int unsigned PW = $clog2(TIMEOUT + 1);
    logic [PW-1:0]  poll_q, poll_d;
`endif

    // Bus address of the access belonging to a given state and word index.
    function automatic logic [31:0] addr_of(input state_t st, input logic [2:0] idx);
        case (st)
            S_WR_KEY:  addr_of = KEY_BASE  + {27'd0, idx, 2'b00};
            S_WR_DIN:  addr_of = DIN_BASE  + {27'd0, idx, 2'b00};
            S_WR_CTRL: addr_of = CTRL_ADDR;
            S_POLL:    addr_of = STATUS_ADDR;
            S_RD_DOUT: addr_of = DOUT_BASE + {27'd0, idx, 2'b00};
            default:   addr_of = 32'h0000_0000;
        endcase
    endfunction

    // Next-state, bus-request and result logic; terminations prioritised err > rty > ack.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        din_d    = din_q;
        dec_d    = dec_q;
        size_d   = size_q;
        data_d   = data_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        issue_s  = 1'b0;
        accept_s = start_i && ready_q;
`ifdef AES_WB_MASTER_TIMEOUT_EN
        poll_d   = poll_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    key_d  = key_i;
                    din_d  = data_i;
                    dec_d  = dec_i;
                    size_d = size_i;
                    idx_d  = 3'd0;
                    if (size_i == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_WR_KEY;
                        issue_s = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_KEY, S_WR_DIN, S_WR_CTRL, S_POLL, S_RD_DOUT: begin
                if (!cyc_q) begin
                    // gap cycle after a termination: (re)issue current access
                    issue_s = 1'b1;
                end else if (wb_err_i) begin
                    cyc_d   = 1'b0;
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (wb_rty_i) begin
                    cyc_d = 1'b0;
                end else if (wb_ack_i) begin
                    cyc_d = 1'b0;
                    case (state_q)
                        S_WR_KEY: begin
                            if (idx_q == (3'd3 + {size_q, 1'b0})) begin
                                state_d = S_WR_DIN;
                                idx_d   = 3'd0;
                            end else begin
                                idx_d = idx_q + 3'd1;
                            end
                        end
                        S_WR_DIN: begin
                            if (idx_q == 3'd3) begin
                                state_d = S_WR_CTRL;
                                idx_d   = 3'd0;
                            end else begin
                                idx_d = idx_q + 3'd1;
                            end
                        end
                        S_WR_CTRL: begin
                            state_d = S_SETTLE;
                            cnt_d   = 4'd0;
                        end
                        S_POLL: begin
                            if (wb_dat_i[0]) begin
`ifdef AES_WB_MASTER_TIMEOUT_EN
                                if (poll_q == PW'(TIMEOUT - 1)) begin
                                    state_d = S_IDLE;
                                    err_d   = 1'b1;
                                end else begin
                                    poll_d = poll_q + {{(PW-1){1'b0}}, 1'b1};
                                end
`else
                                state_d = S_POLL;
`endif
                            end else begin
                                state_d = S_RD_DOUT;
                                idx_d   = 3'd0;
                            end
                        end
                        S_RD_DOUT: begin
                            data_d[{idx_q[1:0], 5'd0} +: 32] = wb_dat_i;
                            if (idx_q == 3'd3) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end else begin
                                idx_d = idx_q + 3'd1;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    cyc_d = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'(SETTLE - 1)) begin
                    state_d = S_POLL;
                    issue_s = 1'b1;
`ifdef AES_WB_MASTER_TIMEOUT_EN
                    poll_d  = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
            end
        endcase

        ready_d = (state_d == S_IDLE) && !accept_s;

        if (issue_s) begin
            cyc_d = 1'b1;
            sel_d = 4'hF;
            adr_d = addr_of(state_d, idx_d);
            we_d  = (state_d == S_WR_KEY) || (state_d == S_WR_DIN) || (state_d == S_WR_CTRL);
            case (state_d)
                S_WR_KEY:  dat_d = key_d[{idx_d, 5'd0} +: 32];
                S_WR_DIN:  dat_d = din_d[{idx_d[1:0], 5'd0} +: 32];
                S_WR_CTRL: dat_d = {28'd0, size_d, dec_d, 1'b1};
                default:   dat_d = 32'h0000_0000;
            endcase
        end else if (!cyc_d) begin
            sel_d = 4'h0;
        end else begin
            sel_d = sel_q;
        end
    end

    // State and registered outputs; reset returns every output to idle at once.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'h0000_0000;
            dat_q   <= 32'h0000_0000;
            sel_q   <= 4'h0;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            key_q   <= 256'd0;
            din_q   <= 128'd0;
            dec_q   <= 1'b0;
            size_q  <= 2'd0;
            data_q  <= 128'd0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef AES_WB_MASTER_TIMEOUT_EN
            poll_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            din_q   <= din_d;
            dec_q   <= dec_d;
            size_q  <= size_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef AES_WB_MASTER_TIMEOUT_EN
            poll_q  <= poll_d;
`endif
        end
    end

    assign ready_o  = ready_q;
    assign data_o   = data_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

endmodule

// File: tb/tb_aes_wb_master.sv
// Scoreboard bench for aes_wb_master: a behavioural Wishbone slave answers
// the master; expected bus accesses and results are queued when a command is
// issued and a monitor checks them as the DUT presents them.
module tb_aes_wb_master;

    localparam int SETTLE = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [255:0] key;
    logic [127:0] din;
    logic         dec;
    logic [1:0]   size;
    logic         ready, done, err;
    logic [127:0] dout;
    logic [31:0]  adr, wdat, rdat;
    logic [3:0]   sel;
    logic         we, cyc, stb, ack, s_err, rty, hit;
    logic [2:0]   cti;
    logic [1:0]   bte;

    always #5 clk = ~clk;

`ifdef AES_WB_MASTER_TIMEOUT_EN
    aes_wb_master #(.TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rstn_i(rst_n), .start_i(start), .key_i(key),
        .data_i(din), .dec_i(dec), .size_i(size), .ready_o(ready),
        .data_o(dout), .done_o(done), .err_o(err), .wb_adr_o(adr),
        .wb_dat_o(wdat), .wb_sel_o(sel), .wb_we_o(we), .wb_cyc_o(cyc),
        .wb_stb_o(stb), .wb_cti_o(cti), .wb_bte_o(bte), .wb_dat_i(rdat),
        .wb_ack_i(ack), .wb_err_i(s_err), .wb_rty_i(rty)
    );
`else
    aes_wb_master dut (
        .wb_clk_i(clk), .wb_rstn_i(rst_n), .start_i(start), .key_i(key),
        .data_i(din), .dec_i(dec), .size_i(size), .ready_o(ready),
        .data_o(dout), .done_o(done), .err_o(err), .wb_adr_o(adr),
        .wb_dat_o(wdat), .wb_sel_o(sel), .wb_we_o(we), .wb_cyc_o(cyc),
        .wb_stb_o(stb), .wb_cti_o(cti), .wb_bte_o(bte), .wb_dat_i(rdat),
        .wb_ack_i(ack), .wb_err_i(s_err), .wb_rty_i(rty)
    );
`endif

    // ---------------- behavioural slave ----------------
    int          busy_left, rty_left;
    logic [31:0] rty_adr, err_adr;
    bit          err_armed;
    logic [31:0] dout_mem [4];

    always_comb begin
        hit   = cyc && stb;
        s_err = hit && err_armed && (adr == err_adr);
        rty   = hit && !s_err && (rty_left > 0) && (adr == rty_adr);
        ack   = hit && !s_err && !rty;
        rdat  = 32'h0;
        if (adr == 32'h44) rdat = {31'd0, (busy_left > 0)};
        else if (adr >= 32'h30 && adr <= 32'h3C) rdat = dout_mem[adr[3:2]];
        else rdat = 32'h0;
    end

    always @(posedge clk) begin
        if (hit) begin
            if (rty) rty_left <= rty_left - 1;
            else if (s_err) err_armed <= 1'b0;
            else if (adr == 32'h44 && busy_left > 0) busy_left <= busy_left - 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed { logic we; logic [31:0] adr; logic [31:0] dat; } acc_t;
    typedef struct packed { logic err; logic [127:0] data; } res_t;
    acc_t exp_acc[$];
    res_t exp_res[$];
    int   tests = 0, fails = 0;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] expv);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic pa(input logic w, input logic [31:0] a, input logic [31:0] d);
        acc_t x;
        x.we = w; x.adr = a; x.dat = d;
        exp_acc.push_back(x);
    endtask

    task automatic push_writes(input logic [255:0] k, input logic [127:0] d, input int nk, input logic [31:0] ctrl);
        for (int i = 0; i < nk; i++) pa(1'b1, 32'(4 * i), k[32*i +: 32]);
        for (int i = 0; i < 4; i++) pa(1'b1, 32'h20 + 32'(4 * i), d[32*i +: 32]);
        pa(1'b1, 32'h40, ctrl);
    endtask

    task automatic push_reads(input int nstat, input int nrd);
        for (int i = 0; i < nstat; i++) pa(1'b0, 32'h44, 32'h0);
        for (int i = 0; i < nrd; i++) pa(1'b0, 32'h30 + 32'(4 * i), 32'h0);
    endtask

    task automatic push_res(input logic e, input logic [127:0] d);
        res_t r;
        r.err = e; r.data = d;
        exp_res.push_back(r);
    endtask

    // Monitor: checks every bus termination and every done/err pulse.
    bit   prev_term, prev_done, prev_err, prev_last, term, last;
    int   settle_cnt;
    acc_t e;
    res_t r;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_term = 0; prev_done = 0; prev_err = 0; prev_last = 0; settle_cnt = 0;
        end else begin
            if (prev_term) chk(!cyc, "gap_after_term", 128'(cyc), 128'd0);
            if (settle_cnt > 1) chk(!cyc, "settle_idle", 128'(cyc), 128'd0);
            else if (settle_cnt == 1) chk(cyc && adr == 32'h44, "settle_then_poll", 128'(adr), 128'h44);
            if (settle_cnt > 0) settle_cnt--;
            if (prev_last) chk(done, "done_after_last_ack", 128'(done), 128'd1);
            if (prev_done) chk(!done && ready, "done_pulse_then_ready", {126'd0, done, ready}, 128'd1);
            if (prev_err) chk(!err, "err_one_pulse", 128'(err), 128'd0);
            term = cyc && (ack || s_err || rty);
            last = 0;
            if (cyc && exp_acc.size() == 0) begin
                chk(1'b0, "unexpected_access", 128'(adr), 128'd0);
            end else if (term) begin
                e = exp_acc[0];
                chk(we == e.we && adr == e.adr && (!e.we || wdat == e.dat) && sel == 4'hF && stb
                    && cti == 3'b000 && bte == 2'b00,
                    "access", {63'd0, we, adr, wdat}, {63'd0, e.we, e.adr, e.dat});
                if (!rty) void'(exp_acc.pop_front());
                if (ack && we && adr == 32'h40) settle_cnt = SETTLE + 1;
                if (ack && !we && adr == 32'h3C) last = 1;
            end
            if (done || err) begin
                if (exp_res.size() == 0) begin
                    chk(1'b0, "unexpected_result", {126'd0, done, err}, 128'd0);
                end else begin
                    r = exp_res.pop_front();
                    chk(done == !r.err && err == r.err, "result_kind", {126'd0, done, err}, {126'd0, !r.err, r.err});
                    chk(dout == r.data, "result_data", dout, r.data);
                end
            end
            prev_term = term; prev_done = done; prev_err = err; prev_last = last;
        end
    end

    // ---------------- stimulus ----------------
    task automatic go(input logic [255:0] k, input logic [127:0] d, input logic dc, input logic [1:0] sz);
        int n = 0;
        while (!ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk(1'b0, "ready_wait", 128'(ready), 128'd1);
        key = k; din = d; dec = dc; size = sz; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || err) && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) chk(1'b0, "end_wait", 128'd0, 128'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic load_dout(input logic [127:0] v);
        for (int i = 0; i < 4; i++) dout_mem[i] = v[32*i +: 32];
    endtask

    logic [255:0] k128, k192, k256;
    logic [127:0] pt, ct128, ct192, ct256, last_data;

    initial begin
        k128  = {128'd0, 128'h000102030405060708090a0b0c0d0e0f};
        k192  = {64'd0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
        k256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        pt    = 128'h00112233445566778899aabbccddeeff;
        ct128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ct192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        ct256 = 128'h8ea2b7ca516745bfeafc49904b496089;
        rst_n = 1'b0; start = 1'b0; key = '0; din = '0; dec = 1'b0; size = 2'd0;
        busy_left = 0; rty_left = 0; rty_adr = 32'h0; err_adr = 32'h0; err_armed = 1'b0;
        load_dout(128'd0);
        repeat (3) @(negedge clk);
        chk(ready == 1'b1, "rst_ready", 128'(ready), 128'd1);
        chk(done == 1'b0 && err == 1'b0, "rst_done_err", {126'd0, done, err}, 128'd0);
        chk(dout == 128'd0, "rst_data", dout, 128'd0);
        chk(cyc == 1'b0 && stb == 1'b0 && we == 1'b0, "rst_cyc_stb_we", {125'd0, cyc, stb, we}, 128'd0);
        chk(adr == 32'h0 && wdat == 32'h0 && sel == 4'h0, "rst_adr_dat_sel", {28'd0, sel, adr, wdat}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 AES-128 encrypt, zero-wait, not busy at first poll
        load_dout(ct128);
        push_writes(k128, pt, 4, 32'h1); push_reads(1, 4); push_res(1'b0, ct128);
        go(k128, pt, 1'b0, 2'd0); wait_end();
        last_data = ct128;

        // AES-256 decrypt, busy for 10 status reads
        load_dout(pt); busy_left = 10;
        push_writes(k256, ct256, 8, 32'hB); push_reads(11, 4); push_res(1'b0, pt);
        go(k256, ct256, 1'b1, 2'd2); wait_end();
        last_data = pt;

        // retry twice on input-block word 2
        load_dout(ct128); rty_adr = 32'h28; rty_left = 2;
        push_writes(k128, pt, 4, 32'h1); push_reads(1, 4); push_res(1'b0, ct128);
        go(k128, pt, 1'b0, 2'd0); wait_end();
        last_data = ct128;

        // bus error on the second key write
        err_adr = 32'h04; err_armed = 1'b1;
        pa(1'b1, 32'h00, k256[31:0]); pa(1'b1, 32'h04, k256[63:32]); push_res(1'b1, last_data);
        go(k256, pt, 1'b0, 2'd2); wait_end();
        chk(ready == 1'b1 && cyc == 1'b0, "err_abort_idle", {126'd0, ready, cyc}, 128'd2);
        repeat (4) @(negedge clk);

        // illegal size: error the cycle after acceptance, no bus traffic
        push_res(1'b1, last_data);
        go(k128, pt, 1'b0, 2'd3);
        chk(err == 1'b1 && cyc == 1'b0, "size3_err", {126'd0, err, cyc}, 128'd2);
        repeat (4) @(negedge clk);

`ifdef AES_WB_MASTER_TIMEOUT_EN
        // busy stuck: exactly TIMEOUT status reads then error
        busy_left = 100;
        push_writes(k128, pt, 4, 32'h1); push_reads(8, 0); push_res(1'b1, last_data);
        go(k128, pt, 1'b0, 2'd0); wait_end();
        busy_left = 0;
        repeat (2) @(negedge clk);
`endif

        // reset during the busy poll, then a normal AES-192 command
        begin
            int n = 0;
            busy_left = 1000;
            push_writes(k128, pt, 4, 32'h1); push_reads(1, 0);
            go(k128, pt, 1'b0, 2'd0);
            do begin @(negedge clk); #2; n++; end while (exp_acc.size() != 0 && n < 200);
            if (n >= 200) chk(1'b0, "poll_reach", 128'd0, 128'd1);
            rst_n = 1'b0;
            #1;
            chk(cyc == 1'b0 && stb == 1'b0, "rst_mid_cyc", {126'd0, cyc, stb}, 128'd0);
            chk(ready == 1'b1 && dout == 128'd0, "rst_mid_ready", {ready, dout[126:0]}, {1'b1, 127'd0});
            exp_acc.delete(); exp_res.delete(); busy_left = 0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end
        load_dout(ct192);
        push_writes(k192, pt, 6, 32'h5); push_reads(1, 4); push_res(1'b0, ct192);
        go(k192, pt, 1'b0, 2'd1); wait_end();

        repeat (5) @(negedge clk);
        chk(exp_acc.size() == 0, "acc_queue_drained", 128'(exp_acc.size()), 128'd0);
        chk(exp_res.size() == 0, "res_queue_drained", 128'(exp_res.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
